polyvecl_pointwise_acc: RTL and testbench

Downstream consumer of the L-polynomial NTT stage. Computes one row of the matrix-vector product in the NTT domain: w[n] = Σ_{j<L} montgomery_reduce(A[j][n] · v̂[j][n]) for all 256 coefficients. A is one row of expanded matrix Â; v̂ is the NTT-domain s1 vector. Uses the same rtr/rts handshake as the surrounding pipeline; the controller invokes it once per row (K times).

---
 rtl/dilithium_pkg.sv | 22 ++
 rtl/polyvecl_pointwise_acc_if.sv | 31 +++
 rtl/montgomery_reduce_32.sv | 19 +
 rtl/polyvecl_pointwise_acc.sv | 163 ++++++++++++++++
 tb/tb_polyvecl_pointwise_acc.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the reduce32 helper.
// Provides N, Q, QINV, L, K, coefficient and packed-poly widths.
package dilithium_pkg;

  localparam int N       = 256;
  localparam int Q       = 8380417;
  localparam int QINV    = 58728449;
  localparam int L       = 5;
  localparam int K       = 6;
  localparam int COEFF_W = 32;
  localparam int POLY_W  = N * COEFF_W;

  // Folds a into roughly [-6283009, 6283007].
  function automatic logic signed [31:0] reduce32(
    input logic signed [31:0] a
  );
    logic signed [31:0] t;
    t = (a + 32'sd4194304) >>> 23;
    return a - t * 32'(Q);
  endfunction

endpackage

// File: rtl/polyvecl_pointwise_acc_if.sv
// rtr/rts handshake plus packed operand/result buses.
// master: upstream controller; slave: polyvecl_pointwise_acc.
interface polyvecl_pointwise_acc_if
  import dilithium_pkg::*;
#(
  parameter int L = 5
);

  logic              rtr;
  logic [L*POLY_W-1:0] linear_a_in;
  logic [L*POLY_W-1:0] linear_v_in;
  logic [POLY_W-1:0] linear_w_out;
  logic              rts;

  modport master (
    output rtr,
    output linear_a_in,
    output linear_v_in,
    input  linear_w_out,
    input  rts
  );

  modport slave (
    input  rtr,
    input  linear_a_in,
    input  linear_v_in,
    output linear_w_out,
    output rts
  );

endinterface

// File: rtl/montgomery_reduce_32.sv
// Combinational Montgomery reduction: r = a * 2^-32 mod Q.
// Ports: a (64-bit signed product), r (32-bit signed, in (-Q, Q)).
module montgomery_reduce_32
  import dilithium_pkg::*;
(
  input  logic signed [63:0] a,
  output logic signed [31:0] r
);

  logic signed [31:0] t;
  logic signed [63:0] tq;

  // Only the low word of the product matters for t.
  assign t  = $signed(a[31:0] * 32'(QINV));
  assign tq = 64'(t) * 64'(Q);
  // a - t*Q has a zero low word, so the shift is exact.
  assign r  = 32'((a - tq) >>> 32);

endmodule

// File: rtl/polyvecl_pointwise_acc.sv
// NTT-domain row product: w[n] = sum_j mont(A[j][n] * v[j][n]).
// Ports: clock, reset (async, high), bus (slave: rtr, a, v -> w, rts).
// Macro POINTWISE_REDUCE32_EN: pass each group through reduce32.
module polyvecl_pointwise_acc
  import dilithium_pkg::*;
#(
  parameter int L     = 5,
  parameter int LANES = 8
)
(
  input logic                      clock,
  input logic                      reset,
  polyvecl_pointwise_acc_if.slave  bus
);

  localparam int G  = N / LANES;
  localparam int JW = (L > 1) ? $clog2(L) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_RTR = 3'd1;
  localparam logic [2:0] LOAD     = 3'd2;
  localparam logic [2:0] MAC      = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]    state;
  logic [JW-1:0] j;
  logic [GW-1:0] g;
  logic          last_j;
  logic          last_issue;

  // Product pipeline tags: what the registered product belongs to.
  logic          prod_vld;
  logic          prod_last;
  logic [GW-1:0] prod_g;

  logic signed [31:0] a_c [L][N];
  logic signed [31:0] v_c [L][N];

  genvar p, n, k, m;

  generate
    for (p = 0; p < L; p++) begin : g_poly
      for (n = 0; n < N; n++) begin : g_coef
        assign a_c[p][n] =
          bus.linear_a_in[POLY_W*p + COEFF_W*n +: COEFF_W];
        assign v_c[p][n] =
          bus.linear_v_in[POLY_W*p + COEFF_W*n +: COEFF_W];
      end
    end
  endgenerate

  assign last_j     = (j == JW'(L - 1));
  assign last_issue = last_j && (g == GW'(G - 1));
  assign bus.rts    = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      j         <= '0;
      g         <= '0;
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
      prod_g    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= WAIT_RTR;
        end
        WAIT_RTR: begin
          if (bus.rtr) state <= LOAD;
        end
        LOAD: begin
          j         <= '0;
          g         <= '0;
          prod_vld  <= 1'b0;
          prod_last <= 1'b0;
          state     <= MAC;
        end
        MAC: begin
          prod_vld  <= 1'b1;
          prod_last <= last_j;
          prod_g    <= g;
          if (last_j) begin
            j <= '0;
            g <= g + GW'(1);
          end else begin
            j <= j + JW'(1);
          end
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          prod_vld  <= 1'b0;
          prod_last <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (!bus.rtr) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      logic [7:0]         idx;
      logic signed [63:0] prod;
      logic signed [31:0] red;
      logic signed [31:0] prod_q;
      logic signed [31:0] acc;
      logic signed [31:0] sum;
      logic signed [31:0] wv;
      logic signed [31:0] w_lane [G];

      assign idx  = 8'(int'(g) * LANES + k);
      assign prod = 64'(a_c[j][idx]) * 64'(v_c[j][idx]);

      montgomery_reduce_32 u_mont (
        .a (prod),
        .r (red)
      );

      // The group's final term is folded in on the write itself.
      assign sum = acc + prod_q;

`ifdef POINTWISE_REDUCE32_EN
      assign wv = reduce32(sum);
`else
      assign wv = sum;
`endif

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          prod_q <= '0;
          acc    <= '0;
          for (int i = 0; i < G; i++) w_lane[i] <= '0;
        end else begin
          if (state == MAC) prod_q <= red;
          if (state == LOAD) begin
            acc <= '0;
          end else if (prod_vld) begin
            if (prod_last) begin
              acc            <= '0;
              w_lane[prod_g] <= wv;
            end else begin
              acc <= sum;
            end
          end
        end
      end

      for (m = 0; m < G; m++) begin : g_out
        assign bus.linear_w_out[COEFF_W*(m*LANES + k) +: COEFF_W] =
          w_lane[m];
      end
    end
  endgenerate

endmodule

// File: tb/tb_polyvecl_pointwise_acc.sv
// Directed bench for polyvecl_pointwise_acc.
// Latency, reset, boundary coefficients, random rows, rtr hold.
module tb_polyvecl_pointwise_acc;
  import dilithium_pkg::*;

  localparam int LP  = 5;
  localparam int LN  = 8;
  localparam int LAT = LP * N / LN + 3;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   any_rts;

  logic [LP*POLY_W-1:0] a_vec;
  logic [LP*POLY_W-1:0] v_vec;
  logic [POLY_W-1:0]    exp_w;
  logic [POLY_W-1:0]    held_w;

  polyvecl_pointwise_acc_if #(.L(LP)) bus ();

  polyvecl_pointwise_acc #(
    .L     (LP),
    .LANES (LN)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int mont(input logic signed [63:0] x);
    logic [31:0]        tt;
    logic signed [63:0] d;
    tt = x[31:0] * 32'(QINV);
    d  = x - $signed({{32{tt[31]}}, tt}) * 64'(Q);
    return int'(d[63:32]);
  endfunction

  function automatic int red32(input int a);
    int t;
    t = (a + (1 << 22)) >>> 23;
    return a - t * Q;
  endfunction

  function automatic int modq(input int x);
    int r;
    r = x % Q;
    if (r < 0) r += Q;
    return r;
  endfunction

  function automatic logic [POLY_W-1:0] model(
    input logic [LP*POLY_W-1:0] a,
    input logic [LP*POLY_W-1:0] v
  );
    logic [POLY_W-1:0]  w;
    logic signed [31:0] x;
    logic signed [31:0] y;
    int                 s;
    for (int nn = 0; nn < N; nn++) begin
      s = 0;
      for (int jj = 0; jj < LP; jj++) begin
        x = a[POLY_W*jj + 32*nn +: 32];
        y = v[POLY_W*jj + 32*nn +: 32];
        s += mont(64'(x) * 64'(y));
      end
`ifdef POINTWISE_REDUCE32_EN
      s = red32(s);
`endif
      w[32*nn +: 32] = s;
    end
    return w;
  endfunction

  function automatic int coef(input logic [POLY_W-1:0] w, input int nn);
    return int'($signed(w[32*nn +: 32]));
  endfunction

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [POLY_W-1:0] exp);
    int bad;
    checks++;
    assert (bus.linear_w_out === exp) else begin
      errors++;
      bad = 0;
      for (int nn = N - 1; nn >= 0; nn--)
        if (bus.linear_w_out[32*nn +: 32] !== exp[32*nn +: 32]) bad = nn;
      $error("FAIL %s coeff %0d observed %0d expected %0d", tag, bad,
             coef(bus.linear_w_out, bad), coef(exp, bad));
    end
  endtask

  task automatic clear_vecs();
    a_vec = '0;
    v_vec = '0;
  endtask

  task automatic put(input int p, input int nn, input int a, input int v);
    a_vec[POLY_W*p + 32*nn +: 32] = a;
    v_vec[POLY_W*p + 32*nn +: 32] = v;
  endtask

  // Start a run; count edges from the one that samples rtr until rts.
  task automatic run(input bit hold, output int c);
    bus.linear_a_in = a_vec;
    bus.linear_v_in = v_vec;
    @(negedge clock);
    bus.rtr = 1'b1;
    c = 0;
    while (c < 400) begin
      @(posedge clock);
      #1;
      c++;
      if (!hold) bus.rtr = 1'b0;
      if (bus.rts === 1'b1) break;
    end
    if (!hold) begin
      bus.rtr = 1'b0;
      repeat (3) @(posedge clock);
      #1;
    end
  endtask

  task automatic rand_vecs();
    for (int p = 0; p < LP; p++)
      for (int nn = 0; nn < N; nn++)
        put(p, nn,
            int'($urandom_range(0, 2*Q - 2)) - (Q - 1),
            int'($urandom_range(0, 2*Q - 2)) - (Q - 1));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.rtr = 1'b0;
    clear_vecs();
    bus.linear_a_in = a_vec;
    bus.linear_v_in = v_vec;

    repeat (3) @(posedge clock);
    #1;
    chk_int("reset_rts", int'(bus.rts), 0);
    chk_w("reset_w", '0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);

    // All zero inputs.
    run(1'b0, cyc);
    chk_int("zero_latency", cyc, LAT);
    chk_w("zero_w", '0);

    // Single Montgomery pair at coeff 0.
    clear_vecs();
    put(0, 0, 4193792, 5);
    run(1'b0, cyc);
    chk_int("c0_latency", cyc, LAT);
    chk_int("c0_modq", modq(coef(bus.linear_w_out, 0)), 5);
`ifdef POINTWISE_REDUCE32_EN
    chk_int("c0_exact", coef(bus.linear_w_out, 0), 5);
`endif
    chk_w("c0_w", model(a_vec, v_vec));

    // Same pair in every poly at coeff 255.
    clear_vecs();
    for (int p = 0; p < LP; p++) put(p, 255, 4193792, 5);
    run(1'b0, cyc);
    chk_int("c255_modq", modq(coef(bus.linear_w_out, 255)), 25);
    chk_w("c255_w", model(a_vec, v_vec));

    // Lane/group boundary coefficients 7 and 8.
    clear_vecs();
    for (int p = 0; p < LP; p++) begin
      put(p, 7, 4193792, 3);
      put(p, 8, 4193792, 4);
    end
    run(1'b0, cyc);
    chk_int("c7_modq", modq(coef(bus.linear_w_out, 7)), 15);
    chk_int("c8_modq", modq(coef(bus.linear_w_out, 8)), 20);
    chk_w("c78_w", model(a_vec, v_vec));

    // Random rows.
    for (int r = 0; r < 20; r++) begin
      rand_vecs();
      exp_w = model(a_vec, v_vec);
      run(1'b0, cyc);
      chk_int($sformatf("rand%0d_latency", r), cyc, LAT);
      chk_w($sformatf("rand%0d_w", r), exp_w);
      // Output must hold while idle.
      repeat (5) @(posedge clock);
      #1;
      chk_w($sformatf("rand%0d_hold", r), exp_w);
    end

    // Reset in the middle of MAC.
    rand_vecs();
    exp_w = model(a_vec, v_vec);
    bus.linear_a_in = a_vec;
    bus.linear_v_in = v_vec;
    @(negedge clock);
    bus.rtr = 1'b1;
    @(posedge clock);
    #1;
    bus.rtr = 1'b0;
    repeat (79) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk_int("midreset_rts", int'(bus.rts), 0);
    chk_w("midreset_w", '0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    run(1'b0, cyc);
    chk_int("after_reset_latency", cyc, LAT);
    chk_w("after_reset_w", exp_w);

    // rtr held high past DONE.
    rand_vecs();
    exp_w = model(a_vec, v_vec);
    run(1'b1, cyc);
    chk_int("hold_latency", cyc, LAT);
    chk_w("hold_w", exp_w);
    held_w = bus.linear_w_out;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      chk_int($sformatf("hold_rts%0d", i), int'(bus.rts), 1);
      chk_w($sformatf("hold_stable%0d", i), held_w);
    end
    @(negedge clock);
    bus.rtr = 1'b0;
    @(posedge clock);
    #1;
    chk_int("drop_rts", int'(bus.rts), 0);
    any_rts = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (bus.rts === 1'b1) any_rts++;
    end
    chk_int("no_second_run", any_rts, 0);
    chk_w("idle_w", held_w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
